// File: rtl/regs_wr_sched.sv
// Merges ALU, load-return and debug writers onto the single register-file write port,
// and keeps a busy scoreboard of in-flight load destinations for decode hazard detection.
module regs_wr_sched #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CPU_WIDTH      = 32,
  parameter int unsigned REG_DATA_DEPTH = 32,
  parameter int unsigned DBG_STARVE     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wr_addr_i,
  input  logic [CPU_WIDTH-1:0]      ex_wr_data_i,
  input  logic                      lsu_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [CPU_WIDTH-1:0]      lsu_data_i,
  output logic                      lsu_ready_o,
  input  logic                      dbg_req_i,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr_i,
  input  logic [CPU_WIDTH-1:0]      dbg_data_i,
  output logic                      dbg_ack_o,
  input  logic                      sb_set_i,
  input  logic [REG_ADDR_WIDTH-1:0] sb_set_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  output logic                      id_hazard_o,
  output logic                      reg_wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_o,
  output logic [CPU_WIDTH-1:0]      reg_wr_data_o
);

  localparam int unsigned CntW = (DBG_STARVE > 0) ? $clog2(DBG_STARVE + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(DBG_STARVE);

  typedef enum logic [1:0] {StIdle, StWait, StAck} dbg_state_e;
  typedef enum logic [2:0] {GntNone, GntEx, GntBuf, GntLive, GntDbg} gnt_e;

  dbg_state_e dbg_state_q, dbg_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic dbg_ack_q, dbg_ack_d;

  logic                      buf_valid_q, buf_valid_d;
  logic [REG_ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic [CPU_WIDTH-1:0]      buf_data_q, buf_data_d;

  logic                      reg_wr_en_q, reg_wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_q, reg_wr_addr_d;
  logic [CPU_WIDTH-1:0]      reg_wr_data_q, reg_wr_data_d;
  logic                      wr_lsu_q, wr_lsu_d;

  logic [REG_DATA_DEPTH-1:0] busy_q, busy_d;

  gnt_e                      gnt;
  logic                      dbg_pend, starving, lsu_acc;
  logic [REG_ADDR_WIDTH-1:0] wr_addr;
  logic [CPU_WIDTH-1:0]      wr_data;

  // Write-port arbitration; a starving debug request jumps ahead of both LSU sources.
  always_comb begin
    dbg_pend = (dbg_state_q == StWait) && dbg_req_i;
    starving = (cnt_q == StarveMax);
    lsu_acc  = lsu_valid_i && !buf_valid_q;
    gnt      = GntNone;
    if (ex_wr_en_i)               gnt = GntEx;
    else if (starving && dbg_pend) gnt = GntDbg;
    else if (buf_valid_q)          gnt = GntBuf;
    else if (lsu_acc)              gnt = GntLive;
    else if (dbg_pend)             gnt = GntDbg;

    wr_addr = '0;
    wr_data = '0;
    unique case (gnt)
      GntEx:   begin wr_addr = ex_wr_addr_i; wr_data = ex_wr_data_i; end
      GntBuf:  begin wr_addr = buf_addr_q;   wr_data = buf_data_q;   end
      GntLive: begin wr_addr = lsu_addr_i;   wr_data = lsu_data_i;   end
      GntDbg:  begin wr_addr = dbg_addr_i;   wr_data = dbg_data_i;   end
      default: ;
    endcase
  end

  always_comb begin
    // x0 grants complete the handshake but never reach the register file
    reg_wr_en_d   = (gnt != GntNone) && (wr_addr != '0);
    reg_wr_addr_d = reg_wr_en_d ? wr_addr : reg_wr_addr_q;
    reg_wr_data_d = reg_wr_en_d ? wr_data : reg_wr_data_q;
    wr_lsu_d      = reg_wr_en_d && ((gnt == GntBuf) || (gnt == GntLive));

    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (gnt == GntBuf) buf_valid_d = 1'b0;
    if (lsu_acc && (gnt != GntLive)) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = lsu_addr_i;
      buf_data_d  = lsu_data_i;
    end

    // Clear first so a same-edge set of the same register wins
    busy_d = busy_q;
    if (reg_wr_en_q && wr_lsu_q) busy_d[reg_wr_addr_q] = 1'b0;
    if (sb_set_i && (sb_set_addr_i != '0)) busy_d[sb_set_addr_i] = 1'b1;
  end

  always_comb begin
    dbg_state_d = dbg_state_q;
    cnt_d       = cnt_q;
    unique case (dbg_state_q)
      StIdle: begin
        cnt_d = '0;
        if (dbg_req_i) dbg_state_d = StWait;
      end
      StWait: begin
        if (!dbg_req_i) begin
          dbg_state_d = StIdle;
          cnt_d       = '0;
        end else if (gnt == GntDbg) begin
          dbg_state_d = StAck;
        end else if (cnt_q != StarveMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck: begin
        dbg_state_d = StIdle;
        cnt_d       = '0;
      end
      default: begin
        dbg_state_d = StIdle;
        cnt_d       = '0;
      end
    endcase
    dbg_ack_d = (dbg_state_d == StAck);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_state_q   <= StIdle;
      cnt_q         <= '0;
      dbg_ack_q     <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_addr_q    <= '0;
      buf_data_q    <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_addr_q <= '0;
      reg_wr_data_q <= '0;
      wr_lsu_q      <= 1'b0;
      busy_q        <= '0;
    end else begin
      dbg_state_q   <= dbg_state_d;
      cnt_q         <= cnt_d;
      dbg_ack_q     <= dbg_ack_d;
      buf_valid_q   <= buf_valid_d;
      buf_addr_q    <= buf_addr_d;
      buf_data_q    <= buf_data_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      wr_lsu_q      <= wr_lsu_d;
      busy_q        <= busy_d;
    end
  end

  assign lsu_ready_o   = !buf_valid_q;
  assign dbg_ack_o     = dbg_ack_q;
  assign reg_wr_en_o   = reg_wr_en_q;
  assign reg_wr_addr_o = reg_wr_addr_q;
  assign reg_wr_data_o = reg_wr_data_q;
  assign id_hazard_o   = ((id_rs1_addr_i != '0) && busy_q[id_rs1_addr_i]) ||
                         ((id_rs2_addr_i != '0) && busy_q[id_rs2_addr_i]);

endmodule
